// File: rtl/or1200_alu_arb_pkg.sv
// Shared types and constants for the or1200 ALU arbiter slice.
// Op widths and encodings mirror or1200_defines; nothing new is defined here.
package or1200_alu_arb_pkg;

    localparam int OPERAND_W = 32;
    localparam int NREQ_MAX  = 8;

    localparam int ALUOP_W   = 4;
    localparam int SHROTOP_W = 2;
    localparam int COMPOP_W  = 4;

    localparam logic [ALUOP_W-1:0]  ALUOP_ADD  = 4'd0;
    localparam logic [ALUOP_W-1:0]  ALUOP_ADDC = 4'd1;
    localparam logic [ALUOP_W-1:0]  ALUOP_COMP = 4'd11;
    localparam logic [ALUOP_W-1:0]  ALUOP_CMOV = 4'd14;
    localparam logic [COMPOP_W-1:0] COP_SFEQ   = 4'd0;

    typedef struct packed {
        logic [ALUOP_W-1:0]   alu_op;
        logic [SHROTOP_W-1:0] shrot_op;
        logic [COMPOP_W-1:0]  comp_op;
        logic [OPERAND_W-1:0] a;
        logic [OPERAND_W-1:0] b;
    } alu_req_t;

    // Round-robin successor of a granted index, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/or1200_alu_arb_if.sv
// Requester-side bus of the ALU arbiter: request handshake, response and flag contexts.
interface or1200_alu_arb_if
    import or1200_alu_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32
);
    logic [NREQ-1:0]                req_valid;
    logic [NREQ-1:0]                req_ready;
    logic [NREQ-1:0][ALUOP_W-1:0]   req_alu_op;
    logic [NREQ-1:0][SHROTOP_W-1:0] req_shrot_op;
    logic [NREQ-1:0][COMPOP_W-1:0]  req_comp_op;
    logic [NREQ-1:0][WIDTH-1:0]     req_a;
    logic [NREQ-1:0][WIDTH-1:0]     req_b;
    logic [NREQ-1:0]                ctx_clr;
    logic [NREQ-1:0]                rsp_valid;
    logic [NREQ-1:0]                rsp_ready;
    logic [WIDTH-1:0]               rsp_result;
    logic                           rsp_flag_we;
    logic                           rsp_cy_we;
    logic [NREQ-1:0]                ctx_flag;
    logic [NREQ-1:0]                ctx_cy;

    modport master (
        output req_valid, req_alu_op, req_shrot_op, req_comp_op, req_a, req_b,
               ctx_clr, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flag_we, rsp_cy_we,
               ctx_flag, ctx_cy
    );

    modport slave (
        input  req_valid, req_alu_op, req_shrot_op, req_comp_op, req_a, req_b,
               ctx_clr, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flag_we, rsp_cy_we,
               ctx_flag, ctx_cy
    );

endinterface

// File: rtl/or1200_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at/after the pointer.
module or1200_rr_arbiter
    import or1200_alu_arb_pkg::*;
#(
    parameter  int NREQ  = 2,
    localparam int PTR_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             en,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] gnt_idx
);

    logic [PTR_W-1:0] ptr;
    logic             found;
    int               idx;

    // Scan from the pointer with wrap-around; no grant while the stage is busy.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        if (en) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(ptr) + k) % NREQ;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_idx  = PTR_W'(idx);
                end
            end
        end
    end

    // Pointer moves past the winner only when a transfer happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= PTR_W'(rr_next(int'(gnt_idx), NREQ));
        end
    end

endmodule

// File: rtl/or1200_alu_arb.sv
// Shares one combinational ALU between NREQ requesters with a registered
// response stage and per-requester SR[F]/SR[CY] shadow contexts.
// The struct operands are OPERAND_W wide, so WIDTH is expected to equal it.
module or1200_alu_arb
    import or1200_alu_arb_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NREQ  = 2,
    localparam int PTR_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    or1200_alu_arb_if.slave      bus,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [ALUOP_W-1:0]   alu_alu_op,
    output logic [SHROTOP_W-1:0] alu_shrot_op,
    output logic [COMPOP_W-1:0]  alu_comp_op,
    output logic                 alu_carry,
    output logic                 alu_flag,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_flagforw,
    input  logic                 alu_flag_we,
    input  logic                 alu_cyforw,
    input  logic                 alu_cy_we
);

    logic             stage_free;
    logic             transfer;
    logic [NREQ-1:0]  gnt;
    logic [PTR_W-1:0] gnt_idx;
    alu_req_t         sel;

    // A drain in the same cycle frees the stage, giving one op per cycle.
    assign stage_free = ~(|bus.rsp_valid) | (|(bus.rsp_valid & bus.rsp_ready));

    or1200_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req_valid),
        .en      (stage_free),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign bus.req_ready = gnt;
    assign transfer      = |gnt;

    // Steer the granted request to the ALU; everything reads zero without a grant.
    always_comb begin
        sel = '0;
        if (transfer) begin
            sel.alu_op   = bus.req_alu_op[gnt_idx];
            sel.shrot_op = bus.req_shrot_op[gnt_idx];
            sel.comp_op  = bus.req_comp_op[gnt_idx];
            sel.a        = bus.req_a[gnt_idx];
            sel.b        = bus.req_b[gnt_idx];
        end
    end

    assign alu_a        = sel.a;
    assign alu_b        = sel.b;
    assign alu_alu_op   = sel.alu_op;
    assign alu_shrot_op = sel.shrot_op;
    assign alu_comp_op  = sel.comp_op;
    assign alu_carry    = transfer & bus.ctx_cy[gnt_idx];
    assign alu_flag     = transfer & bus.ctx_flag[gnt_idx];

    // Response register: load on accept, hold until the owner consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid   <= '0;
            bus.rsp_result  <= '0;
            bus.rsp_flag_we <= 1'b0;
            bus.rsp_cy_we   <= 1'b0;
        end else if (transfer) begin
            bus.rsp_valid   <= gnt;
            bus.rsp_result  <= alu_result;
            bus.rsp_flag_we <= alu_flag_we;
            bus.rsp_cy_we   <= alu_cy_we;
        end else if (|(bus.rsp_valid & bus.rsp_ready)) begin
            bus.rsp_valid   <= '0;
        end
    end

    // Flag/carry shadows follow the granted requester's ALU writes; a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ctx_flag <= '0;
            bus.ctx_cy   <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ctx_clr[i]) begin
                    bus.ctx_flag[i] <= 1'b0;
                    bus.ctx_cy[i]   <= 1'b0;
                end else if (gnt[i]) begin
                    if (alu_flag_we) bus.ctx_flag[i] <= alu_flagforw;
                    if (alu_cy_we)   bus.ctx_cy[i]   <= alu_cyforw;
                end
            end
        end
    end

endmodule

// File: tb/tb_or1200_alu_arb.sv
// Directed bench for or1200_alu_arb with a small behavioural ALU attached.
module tb_or1200_alu_arb;
    import or1200_alu_arb_pkg::*;

    localparam int NREQ  = 2;
    localparam int WIDTH = 32;

    logic                 clk;
    logic                 rst_n;
    logic [WIDTH-1:0]     alu_a, alu_b, alu_result;
    logic [ALUOP_W-1:0]   alu_alu_op;
    logic [SHROTOP_W-1:0] alu_shrot_op;
    logic [COMPOP_W-1:0]  alu_comp_op;
    logic                 alu_carry, alu_flag;
    logic                 alu_flagforw, alu_flag_we, alu_cyforw, alu_cy_we;
    logic [32:0]          sum;
    logic [1:0]           exp_g;

    int total;
    int bad;

    or1200_alu_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    or1200_alu_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_alu_op   (alu_alu_op),
        .alu_shrot_op (alu_shrot_op),
        .alu_comp_op  (alu_comp_op),
        .alu_carry    (alu_carry),
        .alu_flag     (alu_flag),
        .alu_result   (alu_result),
        .alu_flagforw (alu_flagforw),
        .alu_flag_we  (alu_flag_we),
        .alu_cyforw   (alu_cyforw),
        .alu_cy_we    (alu_cy_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for or1200_alu covering ADD, ADDC, SFEQ and CMOV.
    always_comb begin
        sum          = '0;
        alu_result   = '0;
        alu_flagforw = 1'b0;
        alu_flag_we  = 1'b0;
        alu_cyforw   = 1'b0;
        alu_cy_we    = 1'b0;
        case (alu_alu_op)
            ALUOP_ADD: begin
                sum        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = sum[31:0];
                alu_cyforw = sum[32];
                alu_cy_we  = 1'b1;
            end
            ALUOP_ADDC: begin
                sum        = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_carry};
                alu_result = sum[31:0];
                alu_cyforw = sum[32];
                alu_cy_we  = 1'b1;
            end
            ALUOP_COMP: begin
                alu_flagforw = (alu_comp_op == COP_SFEQ) && (alu_a == alu_b);
                alu_flag_we  = 1'b1;
            end
            ALUOP_CMOV: begin
                alu_result = alu_flag ? alu_a : alu_b;
            end
            default: ;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int i, input logic [ALUOP_W-1:0] op,
                                 input logic [COMPOP_W-1:0] cop,
                                 input logic [31:0] a, input logic [31:0] b);
        bus.req_alu_op[i]   = op;
        bus.req_shrot_op[i] = '0;
        bus.req_comp_op[i]  = cop;
        bus.req_a[i]        = a;
        bus.req_b[i]        = b;
        bus.req_valid[i]    = 1'b1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n            = 1'b0;
        bus.req_valid    = '0;
        bus.req_alu_op   = '0;
        bus.req_shrot_op = '0;
        bus.req_comp_op  = '0;
        bus.req_a        = '0;
        bus.req_b        = '0;
        bus.ctx_clr      = '0;
        bus.rsp_ready    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_result", bus.rsp_result, 32'd0);
        checkOutput("rst_cy_we", 32'(bus.rsp_cy_we), 32'd0);
        checkOutput("rst_ctx_flag", 32'(bus.ctx_flag), 32'd0);
        checkOutput("rst_ctx_cy", 32'(bus.ctx_cy), 32'd0);
        rst_n         = 1'b1;
        bus.rsp_ready = 2'b11;

        // Single ADD from requester 0
        applyStimulus(0, ALUOP_ADD, COP_SFEQ, 32'd5, 32'd7);
        #3;
        checkOutput("add_gnt", 32'(bus.req_ready), 32'd1);
        checkOutput("add_alu_a", alu_a, 32'd5);
        nextCycle();
        bus.req_valid = '0;
        checkOutput("add_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("add_result", bus.rsp_result, 32'd12);
        checkOutput("add_flag_we", 32'(bus.rsp_flag_we), 32'd0);
        #3;
        checkOutput("idle_alu_a", alu_a, 32'd0);
        nextCycle();
        checkOutput("add_drain", 32'(bus.rsp_valid), 32'd0);

        // Both requesters every cycle: pointer is at 1, so grants go 1,0,1,0
        applyStimulus(0, ALUOP_ADD, COP_SFEQ, 32'd1, 32'd1);
        applyStimulus(1, ALUOP_ADD, COP_SFEQ, 32'd2, 32'd2);
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
            #3;
            checkOutput("rr_gnt", 32'(bus.req_ready), 32'(exp_g));
            nextCycle();
            checkOutput("rr_rsp_valid", 32'(bus.rsp_valid), 32'(exp_g));
            checkOutput("rr_result", bus.rsp_result, (exp_g == 2'b10) ? 32'd4 : 32'd2);
        end
        bus.req_valid = '0;
        nextCycle();
        checkOutput("rr_drain", 32'(bus.rsp_valid), 32'd0);

        // Carry context: ADD with carry-out, then dependent ADDC
        applyStimulus(1, ALUOP_ADD, COP_SFEQ, 32'hFFFF_FFFF, 32'd1);
        nextCycle();
        checkOutput("cy_add_result", bus.rsp_result, 32'd0);
        checkOutput("cy_ctx_after_add", 32'(bus.ctx_cy), 32'b10);
        applyStimulus(1, ALUOP_ADDC, COP_SFEQ, 32'd0, 32'd0);
        #3;
        checkOutput("cy_alu_carry", 32'(alu_carry), 32'd1);
        nextCycle();
        bus.req_valid = '0;
        checkOutput("cy_addc_result", bus.rsp_result, 32'd1);
        checkOutput("cy_ctx_after_addc", 32'(bus.ctx_cy), 32'b00);
        nextCycle();

        // Flag context: SFEQ then CMOV on requester 0, CMOV on requester 1
        applyStimulus(0, ALUOP_COMP, COP_SFEQ, 32'd3, 32'd3);
        nextCycle();
        checkOutput("sf_flag_we", 32'(bus.rsp_flag_we), 32'd1);
        checkOutput("sf_ctx_flag", 32'(bus.ctx_flag), 32'b01);
        applyStimulus(0, ALUOP_CMOV, COP_SFEQ, 32'hA, 32'hB);
        #3;
        checkOutput("cmov0_alu_flag", 32'(alu_flag), 32'd1);
        nextCycle();
        bus.req_valid = '0;
        checkOutput("cmov0_result", bus.rsp_result, 32'hA);
        applyStimulus(1, ALUOP_CMOV, COP_SFEQ, 32'hA, 32'hB);
        nextCycle();
        bus.req_valid = '0;
        checkOutput("cmov1_rsp_valid", 32'(bus.rsp_valid), 32'b10);
        checkOutput("cmov1_result", bus.rsp_result, 32'hB);
        nextCycle();

        // Back-pressure: response held, no grants until released
        bus.rsp_ready = 2'b00;
        applyStimulus(0, ALUOP_ADD, COP_SFEQ, 32'd10, 32'd20);
        #3;
        checkOutput("stall_first_gnt", 32'(bus.req_ready), 32'b01);
        nextCycle();
        bus.req_valid = '0;
        applyStimulus(1, ALUOP_ADD, COP_SFEQ, 32'd1, 32'd1);
        checkOutput("stall_rsp_valid", 32'(bus.rsp_valid), 32'b01);
        for (int k = 0; k < 3; k++) begin
            #3;
            checkOutput("stall_no_gnt", 32'(bus.req_ready), 32'd0);
            checkOutput("stall_hold", bus.rsp_result, 32'd30);
            nextCycle();
        end
        bus.rsp_ready = 2'b01;
        #3;
        checkOutput("release_gnt", 32'(bus.req_ready), 32'b10);
        nextCycle();
        bus.req_valid = '0;
        bus.rsp_ready = 2'b11;
        checkOutput("release_rsp_valid", 32'(bus.rsp_valid), 32'b10);
        checkOutput("release_result", bus.rsp_result, 32'd2);
        nextCycle();
        checkOutput("release_drain", 32'(bus.rsp_valid), 32'd0);

        // Context clear wins over a carry capture; requester 0 flag untouched
        applyStimulus(1, ALUOP_ADD, COP_SFEQ, 32'hFFFF_FFFF, 32'd1);
        bus.ctx_clr = 2'b10;
        nextCycle();
        bus.req_valid = '0;
        bus.ctx_clr   = '0;
        checkOutput("clr_ctx_cy", 32'(bus.ctx_cy), 32'd0);
        checkOutput("clr_other_flag", 32'(bus.ctx_flag), 32'b01);
        nextCycle();

        // Asynchronous reset mid-stream
        bus.rsp_ready = 2'b00;
        applyStimulus(0, ALUOP_ADD, COP_SFEQ, 32'd5, 32'd7);
        nextCycle();
        bus.req_valid = '0;
        checkOutput("pre_rst_valid", 32'(bus.rsp_valid), 32'b01);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("arst_result", bus.rsp_result, 32'd0);
        checkOutput("arst_ctx_flag", 32'(bus.ctx_flag), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
